// File: rtl/sensor_conditioner.sv
// Sensor front end: synchronises and debounces the door/fire contacts, box-averages
// the temperature/luminance ADC codes over 4 ticks and derives hot/dark hysteresis flags.

module sensor_debounce #(
    parameter int DEB_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic s,
    output logic sen
);
    localparam logic [3:0] DEB4 = 4'(DEB_TICKS);

    typedef enum logic {STABLE, PENDING} state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       out_q, out_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STABLE;
            cnt   <= '0;
            out_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            out_q <= out_n;
        end
    end

    // A changed level must be seen on DEB_TICKS consecutive ticks; one agreeing tick restarts.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = out_q;
        case (state)
            STABLE: begin
                if (tick && s != out_q) begin
                    if (DEB4 == 4'd1) begin
                        out_n = ~out_q;
                    end else begin
                        state_n = PENDING;
                        cnt_n   = 4'd1;
                    end
                end
            end
            PENDING: begin
                if (tick) begin
                    if (s == out_q) begin
                        state_n = STABLE;
                        cnt_n   = '0;
                    end else if (cnt + 4'd1 == DEB4) begin
                        state_n = STABLE;
                        cnt_n   = '0;
                        out_n   = ~out_q;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_n = STABLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        sen = out_q;
    end
endmodule

module sensor_conditioner #(
    parameter int TICK_DIV  = 10,
    parameter int DEB_TICKS = 3,
    parameter int TEMP_HI   = 72,
    parameter int TEMP_LO   = 68,
    parameter int LUM_LO    = 13,
    parameter int LUM_HI    = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_raw,
    input  logic       f_raw,
    input  logic [7:0] temp_raw,
    input  logic [7:0] lum_raw,
    output logic       d_sen,
    output logic       f_sen,
    output logic [7:0] temp_sen,
    output logic [7:0] lum_sen,
    output logic       avg_valid,
    output logic       hot,
    output logic       dark
);
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0] T_HI = 8'(TEMP_HI);
    localparam logic [7:0] T_LO = 8'(TEMP_LO);
    localparam logic [7:0] L_LO = 8'(LUM_LO);
    localparam logic [7:0] L_HI = 8'(LUM_HI);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + TW'(1);
    end

    // Two-flop synchronisers; bit 1 is the metastability-safe level.
    logic [1:0] sync_d, sync_f;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_d <= '0;
            sync_f <= '0;
        end else begin
            sync_d <= {sync_d[0], d_raw};
            sync_f <= {sync_f[0], f_raw};
        end
    end

    sensor_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_d (
        .clk(clk), .reset(reset), .tick(tick), .s(sync_d[1]), .sen(d_sen)
    );

    sensor_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_f (
        .clk(clk), .reset(reset), .tick(tick), .s(sync_f[1]), .sen(f_sen)
    );

    logic [9:0] acc_t, acc_l, sum_t, sum_l;
    logic [7:0] avg_t, avg_l;
    logic [1:0] scnt;

    assign sum_t = acc_t + {2'b00, temp_raw};
    assign sum_l = acc_l + {2'b00, lum_raw};
    assign avg_t = 8'(sum_t >> 2);
    assign avg_l = 8'(sum_l >> 2);

    // The 4th tick of a window publishes the averages and flags together and restarts the sums.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_t     <= '0;
            acc_l     <= '0;
            scnt      <= '0;
            temp_sen  <= '0;
            lum_sen   <= '0;
            avg_valid <= 1'b0;
            hot       <= 1'b0;
            dark      <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (tick) begin
                scnt <= scnt + 2'd1;
                if (scnt == 2'd3) begin
                    acc_t     <= '0;
                    acc_l     <= '0;
                    temp_sen  <= avg_t;
                    lum_sen   <= avg_l;
                    avg_valid <= 1'b1;
                    if (avg_t >= T_HI)      hot <= 1'b1;
                    else if (avg_t <= T_LO) hot <= 1'b0;
                    if (avg_l <= L_LO)      dark <= 1'b1;
                    else if (avg_l >= L_HI) dark <= 1'b0;
                end else begin
                    acc_t <= sum_t;
                    acc_l <= sum_l;
                end
            end
        end
    end
endmodule

// File: tb/tb_sensor_conditioner.sv
// Randomised + directed bench for sensor_conditioner; a cycle-level reference model
// predicts every average update and contact edge, and a monitor scores DUT outputs.

module tb_sensor_conditioner;
    localparam int TD  = 10;
    localparam int DEB = 3;
    localparam int THI = 72;
    localparam int TLO = 68;
    localparam int LLO = 13;
    localparam int LHI = 17;
    localparam int HMAX = 32768;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       d_raw = 1'b0, f_raw = 1'b0;
    logic [7:0] temp_raw = '0, lum_raw = '0;
    logic       d_sen, f_sen, avg_valid, hot, dark;
    logic [7:0] temp_sen, lum_sen;

    always #5 clk = ~clk;

    sensor_conditioner #(
        .TICK_DIV(TD), .DEB_TICKS(DEB), .TEMP_HI(THI), .TEMP_LO(TLO), .LUM_LO(LLO), .LUM_HI(LHI)
    ) dut (
        .clk(clk), .reset(reset), .d_raw(d_raw), .f_raw(f_raw),
        .temp_raw(temp_raw), .lum_raw(lum_raw),
        .d_sen(d_sen), .f_sen(f_sen), .temp_sen(temp_sen), .lum_sen(lum_sen),
        .avg_valid(avg_valid), .hot(hot), .dark(dark)
    );

    typedef struct { int cyc; int t; int l; bit h; bit dk; } avg_exp_t;
    typedef struct { int cyc; bit v; } edge_t;

    avg_exp_t aq[$];
    edge_t    dq[$], fq[$];
    int       checks = 0;
    int       errors = 0;

    // Model state: k counts rising edges since reset release; hist[c] is the raw level in cycle c.
    int  k = 0;
    bit  dh[HMAX], fh[HMAX];
    int  ts[$], ls[$];
    bit  m_d, m_f, m_hot, m_dark;
    int  d_run, f_run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic deb(input bit lvl, inout bit o, inout int run, output bit flip);
        flip = 1'b0;
        if (lvl != o) begin
            run++;
            if (run == DEB) begin
                o    = ~o;
                run  = 0;
                flip = 1'b1;
            end
        end else begin
            run = 0;
        end
    endtask

    // Reference model: a contact follows a level seen differing on DEB consecutive ticks,
    // the synchronised level at a tick being the raw level two cycles earlier.
    initial begin
        bit fl;
        int st, sl, at, al;
        forever begin
            @(posedge clk);
            if (reset) begin
                k = 0; ts.delete(); ls.delete();
                m_d = 0; m_f = 0; m_hot = 0; m_dark = 0; d_run = 0; f_run = 0;
                aq.delete(); dq.delete(); fq.delete();
            end else begin
                k++;
                if (k < HMAX) begin dh[k] = d_raw; fh[k] = f_raw; end
                if (k % TD == 0) begin
                    deb((k >= 3) ? dh[k-2] : 1'b0, m_d, d_run, fl);
                    if (fl) dq.push_back('{cyc: k + 1, v: m_d});
                    deb((k >= 3) ? fh[k-2] : 1'b0, m_f, f_run, fl);
                    if (fl) fq.push_back('{cyc: k + 1, v: m_f});
                    ts.push_back(int'(temp_raw));
                    ls.push_back(int'(lum_raw));
                    if (ts.size() == 4) begin
                        st = 0; sl = 0;
                        foreach (ts[i]) st += ts[i];
                        foreach (ls[i]) sl += ls[i];
                        at = st / 4; al = sl / 4;
                        if (at >= THI) m_hot = 1; else if (at <= TLO) m_hot = 0;
                        if (al <= LLO) m_dark = 1; else if (al >= LHI) m_dark = 0;
                        aq.push_back('{cyc: k + 1, t: at, l: al, h: m_hot, dk: m_dark});
                        ts.delete(); ls.delete();
                    end
                end
            end
        end
    end

    // Monitor: scores every update pulse and contact edge, and that outputs hold in between.
    initial begin
        avg_exp_t e, held;
        edge_t    ed;
        logic     pd, pf;
        int       now;
        held = '{0, 0, 0, 0, 0};
        pd = 0; pf = 0;
        forever begin
            @(negedge clk);
            now = k + 1;
            if (reset) begin
                pd = d_sen; pf = f_sen;
                held = '{0, 0, 0, 0, 0};
            end else begin
                if (avg_valid) begin
                    if (aq.size() == 0) begin
                        chk("avg_unexpected_pulse", 1, 0);
                    end else begin
                        e = aq.pop_front();
                        chk("avg_cycle", now, e.cyc);
                        chk("avg_temp", temp_sen, e.t);
                        chk("avg_lum", lum_sen, e.l);
                        chk("avg_hot", hot, e.h);
                        chk("avg_dark", dark, e.dk);
                        held = e;
                    end
                end else begin
                    chk("hold_temp", temp_sen, held.t);
                    chk("hold_lum", lum_sen, held.l);
                    chk("hold_hot", hot, held.h);
                    chk("hold_dark", dark, held.dk);
                end
                while (aq.size() > 0 && aq[0].cyc < now) begin
                    chk("avg_missing_pulse", 0, 1);
                    held = aq.pop_front();
                end
                if (d_sen !== pd) begin
                    if (dq.size() == 0) chk("d_unexpected_edge", d_sen, pd);
                    else begin
                        ed = dq.pop_front();
                        chk("d_edge_cycle", now, ed.cyc);
                        chk("d_edge_value", d_sen, ed.v);
                    end
                    pd = d_sen;
                end
                while (dq.size() > 0 && dq[0].cyc < now) begin
                    chk("d_missing_edge", d_sen, dq[0].v);
                    void'(dq.pop_front());
                end
                if (f_sen !== pf) begin
                    if (fq.size() == 0) chk("f_unexpected_edge", f_sen, pf);
                    else begin
                        ed = fq.pop_front();
                        chk("f_edge_cycle", now, ed.cyc);
                        chk("f_edge_value", f_sen, ed.v);
                    end
                    pf = f_sen;
                end
                while (fq.size() > 0 && fq[0].cyc < now) begin
                    chk("f_missing_edge", f_sen, fq[0].v);
                    void'(fq.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        step(1);
        chk("rst_d_sen", d_sen, 0);
        chk("rst_f_sen", f_sen, 0);
        chk("rst_temp", temp_sen, 0);
        chk("rst_lum", lum_sen, 0);
        chk("rst_valid", avg_valid, 0);
        chk("rst_hot", hot, 0);
        chk("rst_dark", dark, 0);
        step(n - 1);
        reset = 1'b0;
    endtask

    // One tick-aligned window; must start in the first cycle of a window.
    task automatic window(input int t[4], input int l[4], input int et, input int el,
                          input bit eh, input bit edk);
        for (int i = 0; i < 4; i++) begin
            temp_raw = 8'(t[i]);
            lum_raw  = 8'(l[i]);
            step(1);
            chk("valid_low_mid_window", avg_valid, 0);
            step(TD - 1);
        end
        chk("dir_valid_pulse", avg_valid, 1);
        chk("dir_temp", temp_sen, et);
        chk("dir_lum", lum_sen, el);
        chk("dir_hot", hot, eh);
        chk("dir_dark", dark, edk);
    endtask

    initial begin
        int n;
        do_reset(3);
        fork
            begin
                window('{70, 71, 72, 74}, '{0, 1, 2, 4}, 71, 1, 0, 1);
                window('{72, 72, 72, 72}, '{13, 13, 13, 13}, 72, 13, 1, 1);
                window('{70, 70, 71, 70}, '{15, 15, 15, 15}, 70, 15, 1, 1);
                window('{68, 68, 68, 68}, '{17, 17, 17, 17}, 68, 17, 0, 0);
            end
            begin
                step(20);
                d_raw = 1; step(15); d_raw = 0;
                step(60);
                chk("reject_short_pulse", d_sen, 0);
                d_raw = 1; f_raw = 1;
                n = 0;
                while (d_sen !== 1'b1 && n < 40) begin step(1); n++; end
                chk("accept_latency_in_range", (n >= 23 && n <= 33), 1);
                chk("simultaneous_f_rises", f_sen, 1);
                step(50);
                f_raw = 0; step(TD); f_raw = 1;
                step(60);
                chk("f_one_tick_drop_ignored", f_sen, 1);
                chk("d_still_high", d_sen, 1);
                d_raw = 0; f_raw = 0;
                step(60);
                chk("d_released", d_sen, 0);
            end
        join

        // Reset mid-window: pre-reset samples must not leak into the next average.
        temp_raw = 200; lum_raw = 200;
        step(25);
        do_reset(3);
        window('{10, 20, 30, 40}, '{100, 100, 100, 101}, 25, 100, 0, 0);

        fork
            repeat (1500) begin
                temp_raw = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(60, 80));
                lum_raw  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8, 22));
                step($urandom_range(1, 9));
            end
            repeat (300) begin
                d_raw = 1'($urandom);
                step($urandom_range(1, 45));
            end
            repeat (300) begin
                f_raw = 1'($urandom);
                step($urandom_range(1, 45));
            end
        join
        step(TD * 8);
        #6;
        chk("avg_queue_drained", aq.size(), 0);
        chk("d_queue_drained", dq.size(), 0);
        chk("f_queue_drained", fq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
